ksa_sum_pipe: RTL

KSA_SUM_PIPE -- requirements
Module: ksa_sum_pipe

---
 rtl/ksa_sum_pipe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ksa_sum_pipe.sv
// ---------------------------------------------------------------------------
// ksa_sum_pipe
//
// This block is the sum stage of a 32-bit Kogge-Stone adder. The upstream
// prefix tree supplies the final group generate/propagate terms and the
// per-bit propagate. This stage forms the carries, sum, carry-out, signed
// overflow and zero flag. It then buffers each result in a small circular
// FIFO with valid/ready handshakes on both sides.
//
// Parameters
//   FIFO_DEPTH  number of result entries in the output buffer (2 or 4)
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   the prefix-tree result on g_in/p_in/pbit_in/cin is valid
//   in_ready   the block accepts an input this cycle (from registered state)
//   g_in       group generate, bit i = G[i:0]
//   p_in       group propagate, bit i = P[i:0]
//   pbit_in    per-bit propagate a[i]^b[i]
//   cin        carry-in of the addition
//   out_valid  the head result is valid
//   out_ready  downstream consumes the head result this cycle
//   sum        sum of the head result (zero when out_valid=0)
//   cout       carry-out of the head result (zero when out_valid=0)
//   ovf        signed overflow of the head result (zero when out_valid=0)
//   zero       head sum is all zeros (zero when out_valid=0)
//   op_count   number of results consumed downstream, wraps at 16 bits
// ---------------------------------------------------------------------------
module ksa_sum_pipe #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] g_in,
  input  logic [31:0] p_in,
  input  logic [31:0] pbit_in,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        zero,
  output logic [15:0] op_count
);

  // Only depths 2 and 4 are legal, so the pointer width is 1 or 2 bits.
  localparam int PTR_W   = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 35;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Sum computation (purely combinational from the inputs)
  // -------------------------------------------------------------------------
  logic [31:0] carry;
  logic [31:0] sum_calc;
  logic        cout_calc;
  logic        ovf_calc;
  logic        zero_calc;

  assign carry[0] = cin;

  // G[i-1:0]/P[i-1:0] already cover all lower bits. The carry into bit i
  // therefore needs only the external carry-in folded in.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_carry
      assign carry[gi] = g_in[gi-1] | (p_in[gi-1] & cin);
    end
  endgenerate

  assign sum_calc  = pbit_in ^ carry;
  assign cout_calc = g_in[31] | (p_in[31] & cin);
  // Overflow occurs when the carry into the sign bit differs from the carry out.
  assign ovf_calc  = carry[31] ^ cout_calc;
  assign zero_calc = ~|sum_calc;

  // Entry layout: {sum[31:0], cout, ovf, zero}
  logic [ENTRY_W-1:0] entry_d;
  assign entry_d = {sum_calc, cout_calc, ovf_calc, zero_calc};

  // -------------------------------------------------------------------------
  // FIFO control state
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [15:0]      op_count_q, op_count_d;

  logic push;
  logic pop;

  // in_ready depends only on the occupancy register. There is no
  // combinational path from out_ready, so a full buffer refuses input
  // even while it is being drained.
  assign in_ready  = (count_q < CNT_DEPTH);
  assign out_valid = (count_q != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_count_d = op_count_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      op_count_d = op_count_q + 16'd1;
    end

    // A push and a pop on the same edge cancel out in the occupancy count.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage
  // -------------------------------------------------------------------------
  // The payload registers need no reset. A reset empties the buffer through
  // the pointers and the occupancy count, so stale contents are never
  // presented. The buffer is small enough that each entry is a
  // write-enabled register.
  logic [ENTRY_W-1:0] entry_q [FIFO_DEPTH];

  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst && push && (wr_ptr_q == PTR_W'(gi))) begin
          entry_q[gi] <= entry_d;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output payload: the head entry, forced to zero while the buffer is empty
  // -------------------------------------------------------------------------
  logic [ENTRY_W-1:0] head;

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = entry_q[rd_ptr_q];
    end
  end

  assign sum      = head[34:3];
  assign cout     = head[2];
  assign ovf      = head[1];
  assign zero     = head[0];
  assign op_count = op_count_q;

endmodule
